mdu_hilo: RTL
=============

# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO register pair. It sits beside the ALU in the execute stage and takes the same A/B operand buses. It executes MULT/MULTU/DIV/DIVU over multiple cycles, asserting `busy` so the pipeline stalls. HI/LO feed the writeback mux for MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand and HI/LO width; fixed at 32 for this core.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `start`  in  1  launch operation; accepted only when not `busy`.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A`  in  32  multiplicand / dividend (rs).
- `B`  in  32  multiplier / divisor (rt).
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write strobes.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight; pipeline must stall.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `HI`, `LO`  out  32  architectural registers.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE/DONE + `start`:
  - latch `op`;
  - latch magnitudes of A and B (signed ops take absolute value; unsigned ops pass through);
  - latch the result sign bits;
  - clear the 64-bit accumulator and 6-bit counter;
  - go to MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle, LSB first, 32 cycles.
- DIV: restoring divide, one quotient bit per cycle, 32 cycles.
- Counter reaches 31 → FIX.
- FIX:
  - apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend sign;
  - write HI/LO;
  - go to DONE.
- DONE: `done`=1 for one cycle; returns to IDLE, or launches a new op if `start`=1.
- Multiply result: HI = product[63:32], LO = product[31:0].
- Divide result: LO = quotient, HI = remainder.
- Divide by zero: no trap; HI = A, LO = 0xFFFFFFFF, normal latency.
- 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0 (wraps naturally).
- Arithmetic uses unsigned 32-bit magnitudes, a 33-bit partial remainder and a 64-bit product; no overflow flag.
- MTHI/MTLO writes:
  - applied only when `busy`=0; dropped while busy;
  - `hi_we` and `lo_we` together write both registers;
  - write in the same cycle as an accepted `start` takes effect; FIX later overwrites it.
- `start` while `busy`=1: ignored, no queueing.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, HI=0, LO=0, counter=0.
- Reset asserted mid-operation: next edge returns to reset values; the result is discarded.
- Latency, with cycle 0 = `start` sampled:
  - `busy`=1 in cycles 1–33 (32 iterations plus FIX);
  - HI/LO updated at the end of cycle 33;
  - `done`=1 and `busy`=0 in cycle 34.
- `busy` is a registered output, not combinational from `start`. The issuing control logic stalls on `start` itself in cycle 0.
- Back-to-back: `start` in the DONE cycle is accepted; `busy` rises the next cycle.
- HI/LO are stable outputs at all times except their update edge.

## Configuration
- `MDU_DIV_EN` defined: full divider datapath and DIV state built.
- Not defined:
  - DIV/DIVU are no-ops: FSM goes IDLE→DONE, `done` pulses in cycle 1, `busy` stays 0, HI/LO unchanged;
  - the divider sub-module is not instantiated.
- MULT/MULTU behaviour is identical either way.

## Structure
- Shared package `cpu_pkg`:
  - op encodings `MDU_MULT`/`MDU_MULTU`/`MDU_DIV`/`MDU_DIVU`;
  - FSM state enum;
  - `MDU_ITERS` = 32.
- One sub-module, `mdu_div_step`: combinational single restoring step (33-bit remainder, divisor → next remainder, quotient bit). Instantiated only under `MDU_DIV_EN`.
- Top level holds the FSM, counter, sign/magnitude logic, shift-add multiplier and HI/LO.

## Test plan
- MULT A=0xFFFFFFFE, B=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA; `done` in cycle 34, `busy` high cycles 1–33.
- MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 → LO=3, HI=1.
- DIV A=0x12345678, B=0 → HI=0x12345678, LO=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `start` pulsed at cycle 5 of a MULT → ignored, single `done`; `reset`=0 at cycle 10 → next cycle `busy`=0, HI=LO=0, no `done`.
- `hi_we` with `wdata`=0xA5A5A5A5 while idle → HI=0xA5A5A5A5 next cycle; `lo_we` during busy → LO unchanged until FIX.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings, FSM states and helpers for the multiply/divide unit.
package cpu_pkg;

   localparam int MDU_ITERS = 32;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_e;

   // Signed operands are reduced to their magnitude; unsigned ones pass through.
   function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
      if (is_signed && v[31]) begin
         mdu_abs = 32'd0 - v;
      end else begin
         mdu_abs = v;
      end
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step producing a quotient bit.
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] diff;

   // Subtract when the shifted remainder covers the divisor, otherwise restore.
   always_comb begin
      diff  = rem_in - {1'b0, divisor};
      q_bit = (rem_in >= {1'b0, divisor});
      if (q_bit) begin
         rem_out = diff[WIDTH-1:0];
      end else begin
         rem_out = rem_in[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO register pair.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU complete as no-ops.
module mdu_hilo
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [5:0] LAST_ITER = 6'(MDU_ITERS - 1);

   mdu_state_e         state, next_state, start_target;
   logic               accept, is_signed;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   opnd, shft;
   logic [2*WIDTH-1:0] acc;
   logic [5:0]         count;
   logic               neg_res, neg_rem, div_zero;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MDU_DIV_EN
   logic [WIDTH-1:0]   rem_next;
   logic               q_bit;

   // Remainder lives in acc upper half; dividend bits shift out of shft MSB first.
   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  ({acc[2*WIDTH-1:WIDTH], shft[WIDTH-1]}),
      .divisor (opnd),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );
`endif

   assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                      (shft[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

   // Pick the first working state for a newly accepted operation.
   always_comb begin
      if (op[1]) begin
`ifdef MDU_DIV_EN
         start_target = ST_DIV;
`else
         start_target = ST_DONE;
`endif
      end else begin
         start_target = ST_MUL;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (start) next_state = start_target;
            else       next_state = ST_IDLE;
         end
         ST_MUL: begin
            if (count == LAST_ITER) next_state = ST_FIX;
            else                    next_state = ST_MUL;
         end
`ifdef MDU_DIV_EN
         ST_DIV: begin
            if (count == LAST_ITER) next_state = ST_FIX;
            else                    next_state = ST_DIV;
         end
`endif
         ST_FIX:  next_state = ST_DONE;
         ST_DONE: begin
            if (start) next_state = start_target;
            else       next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Sign correction and result packing applied in FIX.
   always_comb begin
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
      case (op_r)
         MDU_MULT: begin
            if (neg_res) {fix_hi, fix_lo} = {(2*WIDTH){1'b0}} - acc;
            else         {fix_hi, fix_lo} = acc;
         end
         MDU_MULTU: {fix_hi, fix_lo} = acc;
         MDU_DIV, MDU_DIVU: begin
            if (neg_res) fix_lo = {WIDTH{1'b0}} - shft;
            else         fix_lo = shft;
            if (neg_rem) fix_hi = {WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH];
            else         fix_hi = acc[2*WIDTH-1:WIDTH];
            // Divide by zero leaves the dividend as remainder; only LO needs forcing.
            if (div_zero) fix_lo = {WIDTH{1'b1}};
            else          fix_lo = fix_lo;
         end
         default: {fix_hi, fix_lo} = acc;
      endcase
   end

   // Datapath, HI/LO and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_r     <= 2'b00;
         opnd     <= {WIDTH{1'b0}};
         shft     <= {WIDTH{1'b0}};
         acc      <= {(2*WIDTH){1'b0}};
         count    <= 6'd0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         HI       <= {WIDTH{1'b0}};
         LO       <= {WIDTH{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (accept) begin
            op_r     <= op;
            opnd     <= op[1] ? mdu_abs(B, is_signed) : mdu_abs(A, is_signed);
            shft     <= op[1] ? mdu_abs(A, is_signed) : mdu_abs(B, is_signed);
            acc      <= {(2*WIDTH){1'b0}};
            count    <= 6'd0;
            neg_res  <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem  <= is_signed && A[WIDTH-1];
            div_zero <= (B == {WIDTH{1'b0}});
         end else if (state == ST_MUL) begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            shft  <= shft >> 1;
            count <= count + 6'd1;
         end
`ifdef MDU_DIV_EN
         else if (state == ST_DIV) begin
            acc[2*WIDTH-1:WIDTH] <= rem_next;
            shft  <= {shft[WIDTH-2:0], q_bit};
            count <= count + 6'd1;
         end
`endif

         if (state == ST_FIX) begin
            HI <= fix_hi;
            LO <= fix_lo;
         end else if (!busy) begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
         end

         busy <= (next_state == ST_MUL) || (next_state == ST_DIV) || (next_state == ST_FIX);
         done <= (next_state == ST_DONE);
      end
   end

endmodule
